// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU MEM stage and the EXT loader/debug port.
// Optional statistics counters are enabled by defining DATA_MEM_ARB_STATS_EN.
//
// state   | meaning
// ARB     | normal arbitration, CPU has priority unless EXT is starved
// CPU_RET | return cycle of an issued CPU read; EXT may use the RAM
module data_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef DATA_MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_stall_cnt,
  output logic [15:0]       stat_ext_cnt
`endif
);

  typedef enum logic {ARB, CPU_RET} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic              ext_win, cpu_win;
  logic [DATA_W-1:0] cpu_hold, ext_hold;

  // Winners are gated by reset so the RAM sees no access while reset is held.
  always_comb begin
    state_nxt = state;
    ext_win   = 1'b0;
    cpu_win   = 1'b0;
    cpu_stall = 1'b0;
    if (!reset) begin
      if (state == CPU_RET) begin
        ext_win   = ext_req;
        state_nxt = ARB;
      end else begin
        ext_win   = ext_req & (~cpu_req | (starve_cnt == STARVE_MAX));
        cpu_win   = cpu_req & ~ext_win;
        cpu_stall = cpu_req & (ext_win | (cpu_win & ~cpu_we));
        if (cpu_win && !cpu_we) state_nxt = CPU_RET;
      end
    end
  end

  always_comb begin
    starve_nxt = 4'd0;
    if (ext_req && !ext_win)
      starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1;
  end

  // Idle cycles keep the CPU address/data on the bus so the RAM inputs stay stable.
  assign ram_addr  = ext_win ? ext_addr  : cpu_addr;
  assign ram_wdata = ext_win ? ext_wdata : cpu_wdata;
  assign ram_we    = (ext_win & ext_we)  | (cpu_win & cpu_we);
  assign ram_re    = (ext_win & ~ext_we) | (cpu_win & ~cpu_we);
  assign ext_gnt   = ext_win;

  assign cpu_rdata = (state == CPU_RET) ? ram_rdata : cpu_hold;
  assign ext_rdata = ext_rvalid ? ram_rdata : ext_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= 4'd0;
      ext_rvalid <= 1'b0;
      cpu_hold   <= '0;
      ext_hold   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      ext_rvalid <= ext_win & ~ext_we;
      if (state == CPU_RET) cpu_hold <= ram_rdata;
      if (ext_rvalid)       ext_hold <= ram_rdata;
    end
  end

`ifdef DATA_MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stall_cnt <= 16'd0;
      stat_ext_cnt   <= 16'd0;
    end else begin
      if (cpu_stall && stat_stall_cnt != 16'hFFFF) stat_stall_cnt <= stat_stall_cnt + 16'd1;
      if (ext_gnt && stat_ext_cnt != 16'hFFFF)     stat_ext_cnt   <= stat_ext_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios then randomized traffic against
// a transaction-level model with its own shadow copy of the RAM contents.
module tb_data_mem_arbiter;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [7:0] cpu_rdata, ext_rdata, ram_addr, ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic       cpu_stall, ext_gnt, ext_rvalid, ram_we, ram_re;
`ifdef DATA_MEM_ARB_STATS_EN
  logic [15:0] stat_stall_cnt, stat_ext_cnt;
`endif

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
`ifdef DATA_MEM_ARB_STATS_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_ext_cnt(stat_ext_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM with registered read data
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [7:0] shadow [256];
  bit         m_ret, m_ext_pend, last_stall, last_gnt;
  int         m_starve;
  logic [7:0] m_cpu_val, m_cpu_last, m_ext_val, m_ext_last;
  int         m_stall_cnt, m_ext_cnt;

  task automatic model_reset();
    m_ret = 0; m_ext_pend = 0; m_starve = 0;
    m_cpu_val = 8'h00; m_cpu_last = 8'h00; m_ext_val = 8'h00; m_ext_last = 8'h00;
    m_stall_cnt = 0; m_ext_cnt = 0; last_stall = 0; last_gnt = 0;
  endtask

  // Called just after a negedge with inputs already driven; returns after the posedge.
  task automatic cycle();
    bit ew, cw, st, rw, rr;
    #1;
    ew = ext_req && (m_ret || !cpu_req || m_starve == LIMIT);
    cw = !m_ret && cpu_req && !ew;
    st = !m_ret && cpu_req && (ew || (cw && !cpu_we));
    rw = (ew && ext_we) || (cw && cpu_we);
    rr = (ew && !ext_we) || (cw && !cpu_we);
    chk("cpu_stall", cpu_stall, st);
    chk("ext_gnt", ext_gnt, ew);
    chk("ram_we", ram_we, rw);
    chk("ram_re", ram_re, rr);
    if (ew || cw) chk("ram_addr", ram_addr, ew ? ext_addr : cpu_addr);
    if (rw)       chk("ram_wdata", ram_wdata, ew ? ext_wdata : cpu_wdata);
    chk("cpu_rdata", cpu_rdata, m_ret ? m_cpu_val : m_cpu_last);
    chk("ext_rvalid", ext_rvalid, m_ext_pend);
    chk("ext_rdata", ext_rdata, m_ext_pend ? m_ext_val : m_ext_last);
`ifdef DATA_MEM_ARB_STATS_EN
    chk("stat_stall", stat_stall_cnt, m_stall_cnt);
    chk("stat_ext", stat_ext_cnt, m_ext_cnt);
`endif
    @(posedge clk);
    if (st && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
    if (ew && m_ext_cnt < 16'hFFFF)   m_ext_cnt++;
    if (m_ret)      m_cpu_last = m_cpu_val;
    if (m_ext_pend) m_ext_last = m_ext_val;
    m_ext_pend = ew && !ext_we;
    if (m_ext_pend) m_ext_val = shadow[ext_addr];
    m_ret = cw && !cpu_we;
    if (m_ret) m_cpu_val = shadow[cpu_addr];
    if (ew && ext_we) shadow[ext_addr] = ext_wdata;
    if (cw && cpu_we) shadow[cpu_addr] = cpu_wdata;
    m_starve = (ext_req && !ew) ? ((m_starve == LIMIT) ? LIMIT : m_starve + 1) : 0;
    last_stall = st;
    last_gnt   = ew;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [7:0] a, input logic [7:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ext(input bit req, input bit we, input logic [7:0] a, input logic [7:0] d);
    ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      shadow[i] = 8'($urandom);
      mem[i]    = shadow[i];
    end
    reset = 1'b1;
    set_cpu(0, 0, 8'h00, 8'h00);
    set_ext(0, 0, 8'h00, 8'h00);
    model_reset();
    #2;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_gnt", ext_gnt, 0);
    chk("rst_rvalid", ext_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk("rst_ext_rdata", ext_rdata, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: CPU write then read
    set_cpu(1, 1, 8'h10, 8'hA5); cycle();
    @(negedge clk); set_cpu(1, 0, 8'h10, 8'h00);
    #1 chk("t1_read_stall", cpu_stall, 1);
    cycle();
    @(negedge clk);
    #1 chk("t1_rdata", cpu_rdata, 8'hA5);
    chk("t1_ret_stall", cpu_stall, 0);
    cycle();

    // 2: EXT read alone
    @(negedge clk); set_cpu(0, 0, 8'h00, 8'h00); set_ext(1, 0, 8'h10, 8'h00);
    #1 chk("t2_gnt", ext_gnt, 1);
    cycle();
    @(negedge clk); set_ext(0, 0, 8'h00, 8'h00);
    #1 chk("t2_rvalid", ext_rvalid, 1);
    chk("t2_rdata", ext_rdata, 8'hA5);
    cycle();
    @(negedge clk);
    #1 chk("t2_single_pulse", ext_rvalid, 0);
    cycle();

    // 3: starvation under continuous CPU writes
    for (int i = 0; i <= LIMIT; i++) begin
      @(negedge clk);
      set_cpu(1, 1, 8'(8'h40 + i), 8'(i));
      set_ext(1, 1, 8'h30, 8'h5A);
      #1 chk("t3_gnt", ext_gnt, i == LIMIT);
      chk("t3_stall", cpu_stall, i == LIMIT);
      cycle();
    end
    @(negedge clk); set_ext(0, 0, 8'h00, 8'h00); set_cpu(1, 1, 8'h20, 8'h3C);
    cycle();

    // 4: CPU read overlapped with EXT write in the return cycle
    @(negedge clk); set_cpu(1, 0, 8'h20, 8'h00); set_ext(1, 1, 8'h21, 8'h77);
    #1 chk("t4_ext_denied", ext_gnt, 0);
    cycle();
    @(negedge clk);
    #1 chk("t4_ext_gnt_ret", ext_gnt, 1);
    cycle();
    @(negedge clk); set_cpu(0, 0, 8'h00, 8'h00); set_ext(0, 0, 8'h00, 8'h00);
    #1 chk("t4_rdata", cpu_rdata, 8'h3C);
    cycle();

    // 5: reset in the CPU_RET cycle with an EXT read waiting
    @(negedge clk); set_cpu(1, 0, 8'h10, 8'h00); set_ext(1, 0, 8'h21, 8'h00);
    cycle();
    @(negedge clk); reset = 1'b1;
    #1 chk("t5_stall", cpu_stall, 0);
    chk("t5_gnt", ext_gnt, 0);
    chk("t5_ram_we", ram_we, 0);
    chk("t5_ram_re", ram_re, 0);
    chk("t5_cpu_rdata", cpu_rdata, 8'h00);
    chk("t5_rvalid", ext_rvalid, 0);
    chk("t5_ext_rdata", ext_rdata, 8'h00);
    model_reset();
    @(negedge clk); reset = 1'b0;
    set_cpu(0, 0, 8'h00, 8'h00); set_ext(0, 0, 8'h00, 8'h00);
    repeat (3) begin
      cycle();
      @(negedge clk);
    end

    // randomized traffic: stalled CPU and ungranted EXT hold their requests
    for (int n = 0; n < 4000; n++) begin
      if (!last_stall)
        set_cpu($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                8'($urandom_range(0, 15)), 8'($urandom));
      if (!(ext_req && !last_gnt))
        set_ext($urandom_range(0, 99) < 40, $urandom_range(0, 1) == 1,
                8'($urandom_range(0, 15)), 8'($urandom));
      cycle();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
